// File: rtl/rr_pkt_mux_arb.sv
// rr_pkt_mux_arb: round-robin packet arbiter with a registered output beat.
// Optional stall watchdog compiled in with RR_PKT_MUX_ARB_TIMEOUT_EN.
module rr_pkt_mux_arb #(
    parameter int WIDTH     = 32,
    parameter int CNT       = 5,
    parameter int SEL_WIDTH = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT-1:0]       in_valid,
    input  logic [CNT-1:0]       in_last,
    input  logic [WIDTH*CNT-1:0] in_data,
    output logic [CNT-1:0]       in_ready,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [CNT-1:0]       gnt,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_d;
    logic [SEL_WIDTH-1:0] ptr, ptr_d, sel_d;
    logic [SEL_WIDTH-1:0] pick, pick_hi, pick_lo;
    logic [CNT-1:0]       gnt_d;
    logic                 hi_any, lo_any;
    logic                 cur_valid, cur_last;
    logic [WIDTH-1:0]     cur_data;
    logic                 take, accept, wd_fire;

    if ((2 ** SEL_WIDTH) < CNT) begin : g_sel_chk
        $error("SEL_WIDTH too narrow to encode CNT requesters");
    end

    // Round-robin pick: lowest requester above ptr, else lowest overall.
    always_comb begin
        pick_hi = '0;
        pick_lo = '0;
        hi_any  = 1'b0;
        lo_any  = 1'b0;
        for (int i = CNT - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_any  = 1'b1;
                pick_lo = SEL_WIDTH'(i);
            end
            if (in_valid[i] && (i > int'(ptr))) begin
                hi_any  = 1'b1;
                pick_hi = SEL_WIDTH'(i);
            end
        end
        pick = hi_any ? pick_hi : pick_lo;
    end

    // Steer the granted requester's beat using the one-hot grant.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < CNT; i++) begin
            if (gnt[i]) begin
                cur_valid = in_valid[i];
                cur_last  = in_last[i];
                cur_data  = in_data[WIDTH*i +: WIDTH];
            end
        end
    end

    assign busy     = (state == BUSY);
    assign take     = busy && (!out_valid || out_ready);
    assign in_ready = {CNT{take}} & gnt;
    assign accept   = take && cur_valid;

`ifdef RR_PKT_MUX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt, wd_cnt_d;

    // Count stalled grant cycles; fire when the limit is reached.
    always_comb begin
        wd_cnt_d = wd_cnt;
        wd_fire  = 1'b0;
        if (!busy || accept) begin
            wd_cnt_d = '0;
        end else if (!cur_valid) begin
            wd_cnt_d = wd_cnt + CW'(1);
            if (wd_cnt_d == CW'(TIMEOUT)) begin
                wd_fire  = 1'b1;
                wd_cnt_d = '0;
            end
        end
    end

    // Watchdog counter and one-cycle release pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt      <= wd_cnt_d;
            timeout_err <= wd_fire;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next grant state: arbitrate in IDLE, hold the grant for a packet.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        sel_d   = sel;
        gnt_d   = gnt;
        unique case (state)
            IDLE: begin
                if (lo_any) begin
                    state_d = BUSY;
                    sel_d   = pick;
                    gnt_d   = CNT'(1) << pick;
                end
            end
            BUSY: begin
                if ((accept && cur_last) || wd_fire) begin
                    state_d = IDLE;
                    ptr_d   = sel;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= SEL_WIDTH'(CNT - 1);
            sel   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            sel   <= sel_d;
            gnt   <= gnt_d;
        end
    end

    // Output beat register: load on accept, clear on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= cur_last;
            out_data  <= cur_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_pkt_mux_arb.sv
// tb_rr_pkt_mux_arb: directed checks plus a randomized scoreboard run.
// The watchdog section follows RR_PKT_MUX_ARB_TIMEOUT_EN.
module tb_rr_pkt_mux_arb;

    localparam int WIDTH     = 32;
    localparam int CNT       = 5;
    localparam int SEL_WIDTH = 3;
    localparam int TIMEOUT   = 16;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [CNT-1:0]       in_valid;
    logic [CNT-1:0]       in_last;
    logic [WIDTH*CNT-1:0] in_data;
    logic [CNT-1:0]       in_ready;
    logic [SEL_WIDTH-1:0] sel;
    logic [CNT-1:0]       gnt;
    logic                 out_valid;
    logic                 out_last;
    logic [WIDTH-1:0]     out_data;
    logic                 out_ready;
    logic                 busy;
    logic                 timeout_err;

    logic             vld [CNT];
    logic             lst [CNT];
    logic [WIDTH-1:0] dat [CNT];
    logic             rdy [CNT];

    for (genvar g = 0; g < CNT; g++) begin : g_drv
        assign in_valid[g]              = vld[g];
        assign in_last[g]               = lst[g];
        assign in_data[WIDTH*g +: WIDTH] = dat[g];
        assign rdy[g]                   = in_ready[g];
    end

    rr_pkt_mux_arb #(
        .WIDTH(WIDTH), .CNT(CNT), .SEL_WIDTH(SEL_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .sel(sel), .gnt(gnt),
        .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_rx   = 0;
    logic  mon_en = 1'b0;
    beat_t exp_q[$];
    beat_t rq[CNT][$];
    beat_t mq[CNT][$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Scoreboard monitor: pops expected beats on every output transfer.
    logic             hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_data;
    logic             hold_last;
    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (hold_pend) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_data);
                check("hold_last", out_last, hold_last);
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
            if (out_valid && out_ready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_beat: got %0h, want no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_last", out_last, e.last);
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < CNT; i++) begin
            vld[i] = 1'b0;
            lst[i] = 1'b0;
            dat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_beat(input int i, input logic last,
                             input logic [WIDTH-1:0] d);
        bit hit = 0;
        vld[i] = 1'b1;
        lst[i] = last;
        dat[i] = d;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            hit = rdy[i];
            @(posedge clk);
            #1;
        end
        vld[i] = 1'b0;
        if (!hit) begin
            n_chk++;
            $display("FAIL send_timeout: req %0d got no ready, want ready", i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang, want finish");
        $fatal(1);
    end

    initial begin
        int    n, last_c, src, total, rptr, pulses;
        logic  acc [CNT];
        logic  first [CNT];
        int    bub [CNT];
        beat_t b;

        // Reset and idle
        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // Fairness with single-beat packets from every requester
        for (int i = 0; i < CNT; i++) begin
            vld[i] = 1'b1;
            lst[i] = 1'b1;
            dat[i] = 32'hA0 + i;
        end
        n = 0;
        last_c = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (out_valid && n < 6) begin
                src = int'(out_data) - 32'hA0;
                check("rr_order", src, n % CNT);
                check("rr_sel", sel, src);
                if (n > 0) check("rr_gap", c - last_c, 2);
                last_c = c;
                n++;
            end
        end
        check("rr_beats", n, 6);

        // Reset in the middle of a packet
        do_reset();
        send_beat(1, 1'b1, 32'h11);
        send_beat(2, 1'b0, 32'h21);
        send_beat(2, 1'b0, 32'h22);
        check("mid_gnt", gnt, 5'b00100);
        vld[2] = 1'b1;
        dat[2] = 32'h23;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_busy", busy, 0);
        rst_n  = 1'b1;
        vld[2] = 1'b0;
        vld[0] = 1'b1; lst[0] = 1'b1;
        vld[3] = 1'b1; lst[3] = 1'b1;
        @(posedge clk); #1;
        check("post_rst_gnt", gnt, 5'b00001);
        check("post_rst_sel", sel, 0);

        // Randomized packets checked against a packet-level RR model
        do_reset();
        total = 0;
        for (int i = 0; i < CNT; i++) begin
            int np;
            rq[i].delete();
            np = $urandom_range(2, 4);
            for (int p = 0; p < np; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    b.data = {4'(i), 4'(p), 4'(k), 4'h0, 16'($urandom)};
                    b.last = (k == len - 1);
                    rq[i].push_back(b);
                    total++;
                end
            end
            mq[i] = rq[i];
        end
        rptr = CNT - 1;
        for (int guard = 0; guard < 100; guard++) begin
            for (int k = 1; k <= CNT; k++) begin
                int r;
                r = (rptr + k) % CNT;
                if (mq[r].size() > 0) begin
                    do begin
                        b = mq[r].pop_front();
                        exp_q.push_back(b);
                    end while (!b.last);
                    rptr = r;
                    break;
                end
            end
        end
        n_rx   = 0;
        mon_en = 1'b1;
        for (int i = 0; i < CNT; i++) begin
            acc[i]   = 1'b0;
            first[i] = 1'b1;
            bub[i]   = 0;
        end
        for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
            for (int i = 0; i < CNT; i++) begin
                if (acc[i]) begin
                    b = rq[i].pop_front();
                    first[i] = b.last;
                    vld[i]   = 1'b0;
                end
                if (rq[i].size() == 0) begin
                    vld[i] = 1'b0;
                end else begin
                    if (!vld[i]) begin
                        if (first[i] || bub[i] >= 2 || $urandom_range(0, 3) != 0) begin
                            vld[i] = 1'b1;
                            bub[i] = 0;
                        end else begin
                            bub[i]++;
                        end
                    end
                    lst[i] = rq[i][0].last;
                    dat[i] = rq[i][0].data;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int i = 0; i < CNT; i++) acc[i] = vld[i] && rdy[i];
            @(posedge clk); #1;
        end
        for (int i = 0; i < CNT; i++) vld[i] = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_left", exp_q.size(), 0);
        check("rand_count", n_rx, total);
        mon_en = 1'b0;

        // Stalled grant
        do_reset();
        vld[1] = 1'b1;
        lst[1] = 1'b0;
        @(posedge clk); #1;
        check("wd_gnt", gnt, 5'b00010);
        vld[1] = 1'b0;
        vld[2] = 1'b1;
        lst[2] = 1'b1;
        pulses = 0;
`ifdef RR_PKT_MUX_ARB_TIMEOUT_EN
        for (int k = 1; k < TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (timeout_err) pulses++;
        end
        check("wd_early_pulse", pulses, 0);
        check("wd_early_busy", busy, 1);
        @(posedge clk); #1;
        check("wd_pulse", timeout_err, 1);
        check("wd_busy", busy, 0);
        check("wd_gnt_clr", gnt, 0);
        @(posedge clk); #1;
        check("wd_pulse_end", timeout_err, 0);
        check("wd_next_gnt", gnt, 5'b00100);
`else
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            @(posedge clk); #1;
            if (timeout_err) pulses++;
        end
        check("stall_pulses", pulses, 0);
        check("stall_busy", busy, 1);
        check("stall_gnt", gnt, 5'b00010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
